// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle for the sequential binary-to-BCD converter.
// The master drives the conversion request; the slave returns status and packed BCD.
interface bin_to_bcd_seq_if #(
    parameter int unsigned W      = 14,
    parameter int unsigned DIGITS = 4
);
    logic                  start;
    logic [W-1:0]          bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;

    modport master (
        output start, bin,
        input  busy, done, bcd, ovf
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, ovf
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Shift-and-add-3 (double dabble) binary-to-BCD converter, one input bit per clock.
// Produces packed BCD digits for seven-segment decoders; 4'hF means a blanked digit.
module bin_to_bcd_seq #(
    parameter int unsigned W        = 14,
    parameter int unsigned DIGITS   = 4,
    parameter bit          BLANK_LZ = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    bin_to_bcd_seq_if.slave  bus
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned BW = 4 * DIGITS;
    // Zero-extended so the range check never truncates either operand.
    localparam logic [W+31:0] MAXV = (W + 32)'(10 ** DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_shift;
    logic [BW-1:0]   r_scratch;
    logic [CW-1:0]   r_cnt;
    logic            r_ovf_pend;
    logic            r_busy;
    logic            r_done;
    logic [BW-1:0]   r_bcd;
    logic            r_ovf;

    logic            w_ovf_in;
    logic [BW-1:0]   w_adj;
    logic [BW-1:0]   w_blank;
    logic            w_lead;
    logic [BW-1:0]   w_result;

    assign w_ovf_in = ({{32{1'b0}}, bus.bin} > MAXV);

    always_comb begin
        w_adj = r_scratch;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (r_scratch[4*d +: 4] >= 4'd5)
                w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
        end
    end

    // Blank zeros from the top digit down until the first nonzero; units always shown.
    always_comb begin
        w_blank = r_scratch;
        w_lead  = 1'b1;
        for (int unsigned k = 1; k < DIGITS; k++) begin
            if (w_lead && (r_scratch[4*(DIGITS-k) +: 4] == 4'h0))
                w_blank[4*(DIGITS-k) +: 4] = 4'hF;
            else
                w_lead = 1'b0;
        end
    end

    always_comb begin
        if (r_ovf_pend)
            w_result = '1;
        else if (BLANK_LZ)
            w_result = w_blank;
        else
            w_result = r_scratch;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_shift    <= bus.bin;
                        r_scratch  <= '0;
                        r_cnt      <= '0;
                        r_ovf_pend <= w_ovf_in;
                        r_busy     <= 1'b1;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Top bit of the adjusted scratch is discarded; ovf covers that case.
                    r_scratch <= {w_adj[BW-2:0], r_shift[W-1]};
                    r_shift   <= r_shift << 1;
                    r_cnt     <= r_cnt + 1'b1;
                    if (r_cnt == CW'(W - 1))
                        r_state <= FINISH;
                end
                FINISH: begin
                    r_ovf   <= r_ovf_pend;
                    r_bcd   <= w_result;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.bcd  = r_bcd;
    assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: one plain instance and one with leading-zero
// blanking, both fed the same request stream.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [13:0] bin;
    int          total = 0;
    int          bad   = 0;
    int          n;
    int          dones;

    always #5 clk = ~clk;

    bin_to_bcd_seq_if #(.W(14), .DIGITS(4)) ifa ();
    bin_to_bcd_seq_if #(.W(14), .DIGITS(4)) ifb ();

    assign ifa.start = start;
    assign ifa.bin   = bin;
    assign ifb.start = start;
    assign ifb.bin   = bin;

    bin_to_bcd_seq #(.W(14), .DIGITS(4), .BLANK_LZ(1'b0)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    bin_to_bcd_seq #(.W(14), .DIGITS(4), .BLANK_LZ(1'b1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Counts cycles after the accepting edge until done, bounded at 40.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (ifa.done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic convert(input logic [13:0] v, output int cyc);
        bin   = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        tick();
        tick();
        check("rst_busy", 32'(ifa.busy), 32'd0);
        check("rst_done", 32'(ifa.done), 32'd0);
        check("rst_bcd",  32'(ifa.bcd),  32'h0000);
        check("rst_ovf",  32'(ifa.ovf),  32'd0);
        reset = 1'b0;
        tick();

        // Latency and busy window for 1234
        bin   = 14'd1234;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_accept", 32'(ifa.busy), 32'd1);
        n = 0;
        while (ifa.done !== 1'b1 && n < 40) begin
            check("busy_during", 32'(ifa.busy), 32'd1);
            tick();
            n++;
        end
        check("lat_1234",   32'(n),        32'd15);
        check("busy_done",  32'(ifa.busy), 32'd0);
        check("bcd_1234",   32'(ifa.bcd),  32'h1234);
        check("ovf_1234",   32'(ifa.ovf),  32'd0);
        check("bcdB_1234",  32'(ifb.bcd),  32'h1234);
        tick();
        check("done_1cyc",  32'(ifa.done), 32'd0);
        check("bcd_hold",   32'(ifa.bcd),  32'h1234);

        convert(14'd9999, n);
        check("bcd_9999",  32'(ifa.bcd), 32'h9999);
        check("ovf_9999",  32'(ifa.ovf), 32'd0);
        tick();
        convert(14'd10000, n);
        check("bcd_10000",  32'(ifa.bcd), 32'hFFFF);
        check("ovf_10000",  32'(ifa.ovf), 32'd1);
        check("bcdB_10000", 32'(ifb.bcd), 32'hFFFF);
        tick();
        convert(14'd16383, n);
        check("bcd_16383", 32'(ifa.bcd), 32'hFFFF);
        check("ovf_16383", 32'(ifa.ovf), 32'd1);
        tick();

        convert(14'd0, n);
        check("bcd_0",   32'(ifa.bcd), 32'h0000);
        check("ovf_0",   32'(ifa.ovf), 32'd0);
        check("bcdB_0",  32'(ifb.bcd), 32'hFFF0);
        tick();
        convert(14'd205, n);
        check("bcd_205",  32'(ifa.bcd), 32'h0205);
        check("bcdB_205", 32'(ifb.bcd), 32'hF205);
        tick();
        convert(14'd7, n);
        check("bcd_7",  32'(ifa.bcd), 32'h0007);
        check("bcdB_7", 32'(ifb.bcd), 32'hFFF7);
        tick();
        convert(14'd1000, n);
        check("bcdB_1000", 32'(ifb.bcd), 32'h1000);
        tick();

        // Start while busy is ignored, start in the done cycle is accepted
        bin   = 14'd42;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        bin   = 14'd77;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 5;
        while (ifa.done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("lat_42",  32'(n),       32'd15);
        check("bcd_42",  32'(ifa.bcd), 32'h0042);
        bin   = 14'd77;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        check("b2b_gap", 32'(n + 1),   32'd16);
        check("bcd_77",  32'(ifa.bcd), 32'h0077);
        tick();

        // Reset mid-conversion aborts without a done pulse
        convert(14'd1234, n);
        check("bcd_1234b", 32'(ifa.bcd), 32'h1234);
        tick();
        bin   = 14'd5678;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check("abort_busy", 32'(ifa.busy), 32'd0);
        check("abort_done", 32'(ifa.done), 32'd0);
        check("abort_bcd",  32'(ifa.bcd),  32'h0000);
        check("abort_ovf",  32'(ifa.ovf),  32'd0);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ifa.done === 1'b1) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);

        // bin wiggles during conversion must not matter
        bin   = 14'd3141;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (ifa.done !== 1'b1 && n < 40) begin
            bin = 14'($urandom);
            tick();
            n++;
        end
        check("lat_3141", 32'(n),       32'd15);
        check("bcd_3141", 32'(ifa.bcd), 32'h3141);
        check("ovf_3141", 32'(ifa.ovf), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
